// File: rtl/cardio_feature_loader_if.sv
// cardio_feature_loader_if: bundles the raw feature stream, the classifier link, the result stream and the frame-length error flag
// slave: the loader's view (takes s_*, cls_in, m_ready; drives s_ready, feat_vec, m_valid, m_class, err_len); master: the opposite side
interface cardio_feature_loader_if #(
  parameter int NUM_FEAT = 21,
  parameter int FEAT_W = 4,
  parameter int IN_W = 8,
  parameter int CLS_W = 2
);
  logic s_valid;
  logic s_ready;
  logic [IN_W-1:0] s_data;
  logic s_last;
  logic [NUM_FEAT*FEAT_W-1:0] feat_vec;
  logic [CLS_W-1:0] cls_in;
  logic m_valid;
  logic m_ready;
  logic [CLS_W-1:0] m_class;
  logic err_len;
  modport slave(input s_valid, s_data, s_last, cls_in, m_ready, output s_ready, feat_vec, m_valid, m_class, err_len);
  modport master(output s_valid, s_data, s_last, cls_in, m_ready, input s_ready, feat_vec, m_valid, m_class, err_len);
endinterface

// File: rtl/cardio_feature_loader.sv
// cardio_feature_loader: quantizes raw feature beats into a held packed vector and registers the classifier's answer
// ports: clk; rst_n synchronous active-low; bus (slave) carries the s_* beat stream, feat_vec/cls_in classifier link, m_* result stream and err_len pulse
module cardio_feature_loader #(
  parameter int NUM_FEAT = 21,
  parameter int FEAT_W = 4,
  parameter int IN_W = 8,
  parameter int Q_SHIFT = 4,
  parameter int CLS_W = 2,
  parameter int SETTLE_CYC = 1
) (
  input logic clk,
  input logic rst_n,
  cardio_feature_loader_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_FEAT);
  localparam int CNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [IN_W-1:0] Q_MAX = IN_W'((1 << FEAT_W) - 1);
  typedef enum logic [1:0] {LOAD, DRAIN, SETTLE, OUT} state_t;
  state_t state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [IN_W-1:0] shifted;
  logic [FEAT_W-1:0] q;
  logic acc, last_slot, settle_done;
  assign shifted = bus.s_data >> Q_SHIFT;
  assign q = shifted > Q_MAX ? FEAT_W'(Q_MAX) : FEAT_W'(shifted);
  // rst_n gates s_ready directly so upstream sees no acceptance while reset is held
  assign bus.s_ready = rst_n & (state == LOAD || state == DRAIN);
  assign acc = bus.s_valid & bus.s_ready;
  assign last_slot = idx == IDX_W'(NUM_FEAT - 1);
  assign settle_done = cnt == CNT_W'(SETTLE_CYC - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    state_nxt = acc && last_slot ? (bus.s_last ? SETTLE : DRAIN) : LOAD;
      DRAIN:   state_nxt = acc && bus.s_last ? LOAD : DRAIN;
      SETTLE:  state_nxt = settle_done ? OUT : SETTLE;
      default: state_nxt = bus.m_valid && bus.m_ready ? LOAD : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOAD;
      idx <= '0;
      cnt <= '0;
      bus.feat_vec <= '0;
      bus.m_valid <= 1'b0;
      bus.m_class <= '0;
      bus.err_len <= 1'b0;
    end else begin
      state <= state_nxt;
      bus.err_len <= 1'b0;
      if (state == LOAD && acc) begin
        bus.feat_vec[idx*FEAT_W +: FEAT_W] <= q;
        idx <= bus.s_last || last_slot ? '0 : idx + 1'b1;
        // exactly one of "frame ended" and "vector full" means the length was wrong
        bus.err_len <= bus.s_last ^ last_slot;
      end
      cnt <= state == SETTLE && !settle_done ? cnt + 1'b1 : '0;
      if (state == SETTLE && settle_done) begin
        bus.m_valid <= 1'b1;
        bus.m_class <= bus.cls_in;
      end
      if (state == OUT && bus.m_ready) bus.m_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cardio_feature_loader.sv
// tb_cardio_feature_loader: directed and randomized frames checked against a frame-level model of the loader
module tb_cardio_feature_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] tog;
  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int exp_q[21];
  byte unsigned frame[$];
  always #5 clk = ~clk;
  cardio_feature_loader_if bus ();
  cardio_feature_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  function automatic int quant(int d);
    return (d >> 4) > 15 ? 15 : (d >> 4);
  endfunction
  function automatic logic [83:0] pack_exp();
    logic [83:0] v = '0;
    for (int k = 0; k < 21; k++) v[k*4 +: 4] = 4'(exp_q[k]);
    return v;
  endfunction
  function automatic logic [1:0] cls_fn(logic [83:0] v);
    int s = 2;
    for (int k = 0; k < 21; k++) s += int'(v[k*4 +: 4]);
    return 2'(s);
  endfunction
  assign bus.cls_in = cls_fn(bus.feat_vec) ^ tog;
  always @(negedge clk) if (bus.err_len === 1'b1) err_cnt++;
  task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input byte unsigned d, input logic last);
    if ($urandom_range(0, 3) == 0) begin
      bus.s_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b1;
    bus.s_data = d;
    bus.s_last = last;
    chk("s_ready_beat", bus.s_ready, 1'b1);
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1 chk("rst_s_ready", bus.s_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_class", bus.m_class, 2'b0);
    chk("rst_feat_vec", bus.feat_vec, 84'h0);
    chk("rst_err_len", bus.err_len, 1'b0);
    rst_n = 1'b1;
    #1 chk("rel_s_ready", bus.s_ready, 1'b1);
    for (int k = 0; k < 21; k++) exp_q[k] = 0;
  endtask
  task automatic run_frame(input int hold);
    int len = frame.size();
    int e0 = err_cnt;
    for (int i = 0; i < len; i++) begin
      beat(frame[i], i == len - 1);
      if ((len < 21 && i == len - 1) || (len > 21 && i == 20)) chk("err_len_pulse", bus.err_len, 1'b1);
    end
    for (int k = 0; k < 21 && k < len; k++) exp_q[k] = quant(frame[k]);
    if (len == 21) begin
      chk("settle_m_valid", bus.m_valid, 1'b0);
      chk("settle_s_ready", bus.s_ready, 1'b0);
      bus.m_ready = hold == 0;
      @(posedge clk); #1;
      chk("m_valid", bus.m_valid, 1'b1);
      chk("m_class", bus.m_class, cls_fn(pack_exp()));
      chk("feat_vec", bus.feat_vec, pack_exp());
      for (int h = 0; h < hold; h++) begin
        tog = 2'($urandom_range(1, 3));
        @(posedge clk); #1;
        chk("hold_m_valid", bus.m_valid, 1'b1);
        chk("hold_m_class", bus.m_class, cls_fn(pack_exp()));
        chk("hold_feat_vec", bus.feat_vec, pack_exp());
        chk("hold_s_ready", bus.s_ready, 1'b0);
      end
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      tog = 2'b0;
      chk("post_hs_m_valid", bus.m_valid, 1'b0);
      chk("post_hs_s_ready", bus.s_ready, 1'b1);
      chk("no_err_len", 84'(err_cnt - e0), 84'd0);
    end else begin
      repeat (2) @(posedge clk);
      #1;
      chk("bad_len_m_valid", bus.m_valid, 1'b0);
      chk("bad_len_feat_vec", bus.feat_vec, pack_exp());
      chk("bad_len_s_ready", bus.s_ready, 1'b1);
      chk("err_len_count", 84'(err_cnt - e0), 84'd1);
    end
  endtask
  task automatic rand_frame(input int len);
    frame.delete();
    for (int i = 0; i < len; i++) frame.push_back(8'($urandom));
  endtask
  initial begin
    rst_n = 1'b0;
    tog = 2'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b1;
    for (int k = 0; k < 21; k++) exp_q[k] = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m_valid", bus.m_valid, 1'b0);
    chk("reset_feat_vec", bus.feat_vec, 84'h0);
    chk("reset_s_ready", bus.s_ready, 1'b0);
    chk("reset_err_len", bus.err_len, 1'b0);
    rst_n = 1'b1;
    #1 chk("release_s_ready", bus.s_ready, 1'b1);
    frame.delete();
    repeat (21) frame.push_back(8'h30);
    run_frame(0);
    chk("nominal_vec", bus.feat_vec, 84'h333333333333333333333);
    chk("nominal_class", bus.m_class, 2'b01);
    frame.delete();
    for (int k = 0; k < 16; k++) frame.push_back(8'(k * 16));
    repeat (5) frame.push_back(8'hFF);
    run_frame(0);
    chk("quant_vec", bus.feat_vec, 84'hFFFFFFEDCBA9876543210);
    rand_frame(5);
    run_frame(0);
    rand_frame(21);
    run_frame(0);
    rand_frame(25);
    run_frame(0);
    rand_frame(21);
    run_frame(0);
    rand_frame(21);
    run_frame(10);
    for (int i = 0; i < 10; i++) beat(8'($urandom), 1'b0);
    do_reset();
    rand_frame(21);
    run_frame(0);
    rand_frame(21);
    for (int i = 0; i < 21; i++) beat(frame[i], i == 20);
    bus.m_ready = 1'b0;
    @(posedge clk); #1;
    chk("out_before_reset", bus.m_valid, 1'b1);
    do_reset();
    bus.m_ready = 1'b1;
    rand_frame(21);
    run_frame(0);
    for (int n = 0; n < 6; n++) begin
      rand_frame($urandom_range(0, 2) == 0 ? $urandom_range(1, 26) : 21);
      run_frame($urandom_range(0, 3));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
